// File: rtl/serdes_pkg.sv
// Shared types and Hamming SEC helpers for the serdes loopback link.
// Helpers work on fixed maximum-width vectors; callers cast to their real widths.
package serdes_pkg;

    localparam int MAX_DW = 32;
    localparam int MAX_CW = 64;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_GAP   = 2'd3
    } tx_state_e;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    // data occupies the LSBs so a plain width cast extracts it
    typedef struct packed {
        logic [7:0]        syn;
        logic [MAX_DW-1:0] data;
    } dec_t;

    function automatic int parity_bits(input int dw);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << p) < dw + p + 1) p = p + 1;
        end
        return p;
    endfunction

    function automatic int cw_width(input int dw, input int ecc);
        return (ecc != 0) ? dw + parity_bits(dw) : dw;
    endfunction

    function automatic logic [MAX_CW-1:0] hamming_encode(input logic [MAX_DW-1:0] data, input int dw);
        logic [MAX_CW-1:0] cw;
        logic              par;
        int                n, p, j;
        cw = '0;
        n  = cw_width(dw, 1);
        p  = parity_bits(dw);
        j  = 0;
        for (int pos = 1; pos <= MAX_CW; pos++) begin
            if (pos <= n && (pos & (pos - 1)) != 0) begin
                cw[pos-1] = data[j];
                j = j + 1;
            end
        end
        for (int k = 0; k < 7; k++) begin
            if (k < p) begin
                par = 1'b0;
                for (int pos = 1; pos <= MAX_CW; pos++) begin
                    if (pos <= n && pos[k]) par = par ^ cw[pos-1];
                end
                cw[(1 << k) - 1] = par;
            end
        end
        return cw;
    endfunction

    function automatic logic [7:0] hamming_syndrome(input logic [MAX_CW-1:0] cw, input int dw);
        int s, n;
        s = 0;
        n = cw_width(dw, 1);
        for (int pos = 1; pos <= MAX_CW; pos++) begin
            if (pos <= n && cw[pos-1]) s = s ^ pos;
        end
        return 8'(s);
    endfunction

    function automatic dec_t hamming_decode(input logic [MAX_CW-1:0] cw, input int dw);
        dec_t              res;
        logic [MAX_CW-1:0] fixed;
        int                syn, n, j;
        n        = cw_width(dw, 1);
        syn      = int'(hamming_syndrome(cw, dw));
        fixed    = cw;
        j        = 0;
        res.syn  = 8'(syn);
        res.data = '0;
        // out-of-range syndromes come from multi-bit errors and are left alone
        if (syn != 0 && syn <= n) fixed[syn-1] = ~fixed[syn-1];
        for (int pos = 1; pos <= MAX_CW; pos++) begin
            if (pos <= n && (pos & (pos - 1)) != 0) begin
                res.data[j] = fixed[pos-1];
                j = j + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/serdes_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
module serdes_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // storage array
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/serdes_core.sv
// Parallel->serial->parallel loopback: FIFO, optional Hamming SEC, LSB-first 1-bit line,
// deserializer with correction, and an optional passive line monitor.
module serdes_core
    import serdes_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int HAS_ECC     = 0,
    parameter int HAS_SNIFFER = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] parallel_in_i,
    input  logic                  valid_in_i,
    output logic                  ready_out_o,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_out_o,
    output logic                  fifo_full_o,
    output logic                  fifo_empty_o
);
    localparam int CW    = cw_width(DATA_WIDTH, HAS_ECC);
    localparam int CNT_W = $clog2(CW + 1);

    logic                  w_pop, w_full, w_empty, w_line_flip, w_rx_done;
    logic [DATA_WIDTH-1:0] w_fifo_data, w_rx_data;
    logic [CW-1:0]         w_tx_cw, w_rx_cw;

    tx_state_e             r_tx_state;
    logic [CW-1:0]         r_tx_sh;
    logic [CNT_W-1:0]      r_tx_cnt;
    logic                  r_line;
    rx_state_e             r_rx_state;
    logic [CW-1:0]         r_rx_sh;
    logic [CNT_W-1:0]      r_rx_cnt;
    logic                  r_rx_bit;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_valid;

    serdes_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_push  (valid_in_i),
        .i_data  (parallel_in_i),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop       = (r_tx_state == TX_IDLE) && !w_empty;
    // error-injection point on the line; tied off in the real link
    assign w_line_flip = 1'b0;
    assign w_rx_cw     = CW'({r_rx_bit, r_rx_sh} >> 1);
    assign w_rx_done   = (r_rx_state == RX_SHIFT) && (r_rx_cnt == CNT_W'(CW - 1));

    if (HAS_ECC != 0) begin : g_ecc
        assign w_tx_cw   = CW'(hamming_encode(MAX_DW'(w_fifo_data), DATA_WIDTH));
        assign w_rx_data = DATA_WIDTH'(hamming_decode(MAX_CW'(w_rx_cw), DATA_WIDTH));
    end else begin : g_raw
        assign w_tx_cw   = w_fifo_data;
        assign w_rx_data = w_rx_cw;
    end

    // transmitter: start bit, CW payload bits LSB-first, one gap bit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_sh    <= '0;
            r_tx_cnt   <= '0;
            r_line     <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (!w_empty) begin
                        r_tx_sh    <= w_tx_cw;
                        r_line     <= 1'b1;
                        r_tx_state <= TX_START;
                    end else begin
                        r_line <= 1'b0;
                    end
                end
                TX_START: begin
                    r_line     <= r_tx_sh[0];
                    r_tx_sh    <= r_tx_sh >> 1;
                    r_tx_cnt   <= CNT_W'(1);
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    if (r_tx_cnt == CNT_W'(CW)) begin
                        r_line     <= 1'b0;
                        r_tx_state <= TX_GAP;
                    end else begin
                        r_line   <= r_tx_sh[0];
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_GAP: begin
                    r_line     <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
                default: begin
                    r_line     <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // receiver: sample line, hunt for start bit, shift CW bits, decode on the last one
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_state <= RX_IDLE;
            r_rx_sh    <= '0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 1'b0;
            r_out      <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_rx_bit <= r_line ^ w_line_flip;
            r_valid  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_bit) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_SHIFT;
                    end
                end
                RX_SHIFT: begin
                    r_rx_sh <= w_rx_cw;
                    if (w_rx_done) begin
                        r_out      <= w_rx_data;
                        r_valid    <= 1'b1;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    if (HAS_SNIFFER != 0) begin : g_sniffer
        logic [15:0] r_frame_cnt;
        logic [15:0] r_corr_cnt;
        logic [7:0]  w_syn;

        if (HAS_ECC != 0) begin : g_syn
            assign w_syn = hamming_syndrome(MAX_CW'(w_rx_cw), DATA_WIDTH);
        end else begin : g_nosyn
            assign w_syn = 8'd0;
        end

        // saturating frame and correction counters
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_frame_cnt <= 16'd0;
                r_corr_cnt  <= 16'd0;
            end else if (w_rx_done) begin
                if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
                if (w_syn != 8'd0 && r_corr_cnt != 16'hFFFF) r_corr_cnt <= r_corr_cnt + 16'd1;
            end
        end
    end

    assign parallel_out_o = r_out;
    assign valid_out_o    = r_valid;
    assign ready_out_o    = !w_full;
    assign fifo_full_o    = w_full;
    assign fifo_empty_o   = w_empty;

endmodule

// File: tb/tb_serdes_core.sv
// Directed bench: one ECC instance and one raw instance of serdes_core, both with the line monitor.
module tb_serdes_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din_e, din_r, pout_e, pout_r;
    logic       vin_e, vin_r, rdy_e, rdy_r, vout_e, vout_r, full_e, full_r, empty_e, empty_r;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    serdes_core #(.FIFO_DEPTH(16), .DATA_WIDTH(8), .HAS_ECC(1), .HAS_SNIFFER(1)) dut_e (
        .clk_i(clk), .rst_n_i(rst_n), .parallel_in_i(din_e), .valid_in_i(vin_e),
        .ready_out_o(rdy_e), .parallel_out_o(pout_e), .valid_out_o(vout_e),
        .fifo_full_o(full_e), .fifo_empty_o(empty_e)
    );

    serdes_core #(.FIFO_DEPTH(16), .DATA_WIDTH(8), .HAS_ECC(0), .HAS_SNIFFER(1)) dut_r (
        .clk_i(clk), .rst_n_i(rst_n), .parallel_in_i(din_r), .valid_in_i(vin_r),
        .ready_out_o(rdy_r), .parallel_out_o(pout_r), .valid_out_o(vout_r),
        .fifo_full_o(full_r), .fifo_empty_o(empty_r)
    );

    typedef struct {
        logic        sel;
        logic [7:0]  din;
        int          lat;
        logic [7:0]  dout;
        logic [15:0] line;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // push one word, optionally flip line bit 'flip' (1-based), record line and first valid_out
    task automatic send(input logic sel, input logic [7:0] d, input int flip,
                        output int lat, output logic [7:0] dout, output logic [15:0] line_v);
        lat = 0; dout = 8'h00; line_v = 16'h0000;
        if (sel) begin din_e = d; vin_e = 1'b1; end
        else     begin din_r = d; vin_r = 1'b1; end
        @(posedge clk); #1;
        vin_e = 1'b0; vin_r = 1'b0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (flip != 0 && c == flip + 1) force dut_e.w_line_flip = 1'b1;
            if (flip != 0 && c == flip + 2) release dut_e.w_line_flip;
            if (c <= 16) line_v[c-1] = sel ? dut_e.r_line : dut_r.r_line;
            if ((sel ? vout_e : vout_r) == 1'b1) begin
                lat  = c;
                dout = sel ? pout_e : pout_r;
            end
        end
    endtask

    initial begin
        int          lat, idx, mcount, mbusy, got, last, seen;
        logic [7:0]  dout;
        logic [15:0] line_v, c0;
        logic        acc, pop;

        // line = {gap, codeword positions CW..1, start}, first bit on the line in bit 0
        tbl[0] = '{1'b1, 8'hA5, 15, 8'hA5, 16'h144F};
        tbl[1] = '{1'b1, 8'h00, 15, 8'h00, 16'h0001};
        tbl[2] = '{1'b1, 8'hFF, 15, 8'hFF, 16'h1EEF};
        tbl[3] = '{1'b1, 8'h3C, 15, 8'h3C, 16'h06C5};
        tbl[4] = '{1'b0, 8'h00, 11, 8'h00, 16'h0001};
        tbl[5] = '{1'b0, 8'hFF, 11, 8'hFF, 16'h01FF};
        tbl[6] = '{1'b0, 8'h01, 11, 8'h01, 16'h0003};

        rst_n = 1'b0; vin_e = 1'b0; vin_r = 1'b0; din_e = 8'h00; din_r = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty_e", empty_e, 1'b1);
        check("rst_ready_e", rdy_e, 1'b1);
        check("rst_full_e", full_e, 1'b0);
        check("rst_valid_e", vout_e, 1'b0);
        check("rst_pout_e", pout_e, 8'h00);
        check("rst_empty_r", empty_r, 1'b1);
        check("rst_valid_r", vout_r, 1'b0);
        check("rst_pout_r", pout_r, 8'h00);
        check("rst_frames_e", dut_e.g_sniffer.r_frame_cnt, 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].sel, tbl[i].din, 0, lat, dout, line_v);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_data", i), dout, tbl[i].dout);
            check($sformatf("vec%0d_line", i), line_v, tbl[i].line);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse", i), tbl[i].sel ? vout_e : vout_r, 1'b0);
            check($sformatf("vec%0d_hold", i), tbl[i].sel ? pout_e : pout_r, tbl[i].dout);
        end
        check("raw_corr_cnt", dut_r.g_sniffer.r_corr_cnt, 16'd0);
        check("raw_frame_cnt", dut_r.g_sniffer.r_frame_cnt, 16'd3);
        check("ecc_corr_clean", dut_e.g_sniffer.r_corr_cnt, 16'd0);
        check("ecc_frame_cnt", dut_e.g_sniffer.r_frame_cnt, 16'd4);

        for (int k = 1; k <= 12; k++) begin
            c0 = dut_e.g_sniffer.r_corr_cnt;
            send(1'b1, 8'h3C, k, lat, dout, line_v);
            check($sformatf("flip%0d_data", k), dout, 8'h3C);
            check($sformatf("flip%0d_latency", k), lat, 15);
            check($sformatf("flip%0d_corr", k), dut_e.g_sniffer.r_corr_cnt, c0 + 16'd1);
            @(posedge clk); #1;
        end
        check("flip_frame_cnt", dut_e.g_sniffer.r_frame_cnt, 16'd16);

        // burst 0..19 with valid held; model FIFO occupancy and one pop per 15-cycle frame
        idx = 0; mcount = 0; mbusy = 0; got = 0; last = 0;
        din_e = 8'h00; vin_e = 1'b1;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(posedge clk);
            acc = vin_e && (mcount != 16);
            pop = (mbusy == 0) && (mcount != 0);
            if (mbusy != 0) mbusy--;
            if (pop) mbusy = 14;
            mcount = mcount + int'(acc) - int'(pop);
            if (acc) idx++;
            #1;
            check("burst_full", full_e, mcount == 16);
            check("burst_ready", rdy_e, mcount != 16);
            if (vout_e) begin
                check($sformatf("burst_data%0d", got), pout_e, got);
                if (got > 0) check($sformatf("burst_gap%0d", got), cyc - last, 15);
                last = cyc;
                got++;
            end
            if (idx == 20) vin_e = 1'b0;
            else din_e = idx[7:0];
        end
        vin_e = 1'b0;
        check("burst_accepted", idx, 20);
        check("burst_received", got, 20);
        @(posedge clk); #1;
        check("burst_drained", empty_e, 1'b1);

        // reset in the middle of a frame with a second word still queued
        din_e = 8'h11; vin_e = 1'b1;
        @(posedge clk); #1;
        din_e = 8'h22;
        @(posedge clk); #1;
        vin_e = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_empty", empty_e, 1'b1);
        check("midrst_valid", vout_e, 1'b0);
        check("midrst_pout", pout_e, 8'h00);
        check("midrst_frames", dut_e.g_sniffer.r_frame_cnt, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (vout_e) seen++;
        end
        check("midrst_no_output", seen, 0);
        check("midrst_still_empty", empty_e, 1'b1);
        send(1'b1, 8'h96, 0, lat, dout, line_v);
        check("postrst_latency", lat, 15);
        check("postrst_data", dout, 8'h96);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
